// File: rtl/vector_sequencer.sv
// vector_sequencer: walks a vector list in synchronous memory and issues
// one-cycle MOVE (pos) / DRAW (draw) requests to the line rasteriser,
// waiting for draw_done between commands and tracking the beam position.
// Optional watchdog on draw_done: define VECSEQ_WATCHDOG_EN.
module vector_sequencer #(
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [2*OUT_WIDTH+1:0] mem_data,
  output logic [OUT_WIDTH-1:0]   x_start,
  output logic [OUT_WIDTH-1:0]   y_start,
  output logic [OUT_WIDTH-1:0]   x_end,
  output logic [OUT_WIDTH-1:0]   y_end,
  output logic                   pos,
  output logic                   draw,
  input  logic                   draw_done,
  output logic                   busy,
  output logic                   frame_done,
  output logic [ADDR_WIDTH-1:0]  vec_count,
  output logic                   error
);

  localparam logic [1:0] CMD_END  = 2'b00;
  localparam logic [1:0] CMD_MOVE = 2'b01;
  localparam logic [1:0] CMD_DRAW = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT} state_t;

  state_t state, state_nxt;

  logic [1:0]           cmd;
  logic [OUT_WIDTH-1:0] ent_x, ent_y;
  logic                 addr_last;
  logic                 wd_expire;

  assign cmd       = mem_data[2*OUT_WIDTH+1 -: 2];
  assign ent_x     = mem_data[2*OUT_WIDTH-1 -: OUT_WIDTH];
  assign ent_y     = mem_data[OUT_WIDTH-1:0];
  // The last address terminates the frame instead of wrapping to 0.
  assign addr_last = &mem_addr;

`ifdef VECSEQ_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  // Cycles spent in WAIT_DONE; zero on entry since it idles at 0 elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wd_cnt <= '0;
    else if (state != S_WAIT) wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th WAIT_DONE cycle; draw_done wins a tie in the FSM.
  assign wd_expire = (state == S_WAIT) && (wd_cnt == WD_LAST);
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        case (cmd)
          CMD_END:  state_nxt = S_IDLE;
          CMD_MOVE,
          CMD_DRAW: state_nxt = S_WAIT;
          default:  state_nxt = addr_last ? S_IDLE : S_FETCH;
        endcase
      end
      S_WAIT: begin
        if (draw_done)      state_nxt = addr_last ? S_IDLE : S_FETCH;
        else if (wd_expire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs derived purely from state.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Registered datapath: address walk, coordinates, request/frame pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      x_start    <= '0;
      y_start    <= '0;
      x_end      <= '0;
      y_end      <= '0;
      pos        <= 1'b0;
      draw       <= 1'b0;
      frame_done <= 1'b0;
      vec_count  <= '0;
`ifdef VECSEQ_WATCHDOG_EN
      error      <= 1'b0;
`endif
    end else begin
      pos        <= 1'b0;
      draw       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_addr <= '0;
          if (start) begin
            vec_count <= '0;
`ifdef VECSEQ_WATCHDOG_EN
            error     <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          case (cmd)
            CMD_END: begin
              frame_done <= 1'b1;
              mem_addr   <= '0;
            end
            CMD_MOVE: begin
              x_end <= ent_x;
              y_end <= ent_y;
              pos   <= 1'b1;
            end
            CMD_DRAW: begin
              x_end <= ent_x;
              y_end <= ent_y;
              draw  <= 1'b1;
            end
            default: begin
              if (addr_last) begin
                frame_done <= 1'b1;
                mem_addr   <= '0;
              end else begin
                mem_addr   <= mem_addr + 1'b1;
              end
            end
          endcase
        end
        S_WAIT: begin
          if (draw_done) begin
            x_start <= x_end;
            y_start <= y_end;
            if (~&vec_count) vec_count <= vec_count + 1'b1;
            if (addr_last) begin
              frame_done <= 1'b1;
              mem_addr   <= '0;
            end else begin
              mem_addr   <= mem_addr + 1'b1;
            end
          end else if (wd_expire) begin
            // Abort: no frame_done, rewind for the next start.
            mem_addr <= '0;
`ifdef VECSEQ_WATCHDOG_EN
            error    <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: expected requests are queued when a
// list is loaded and popped as pos/draw pulses appear. A second instance with
// ADDR_WIDTH=2 covers the end-of-address-space frame termination.
module tb_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        start = 1'b0;
  logic [9:0]  mem_addr;
  logic [17:0] mem_data = '0;
  logic [7:0]  xs, ys, xe, ye;
  logic        pos, draw, busy, frame_done, error;
  logic [9:0]  vec_count;
  logic        resp_done = 1'b0, spur = 1'b0, auto_en = 1'b1;
  logic        draw_done;
  assign draw_done = resp_done | spur;

  logic [17:0] rom [0:1023];
  always @(posedge clk) mem_data <= rom[mem_addr];

  vector_sequencer #(.OUT_WIDTH(8), .ADDR_WIDTH(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
    .x_start(xs), .y_start(ys), .x_end(xe), .y_end(ye), .pos(pos), .draw(draw),
    .draw_done(draw_done), .busy(busy), .frame_done(frame_done),
    .vec_count(vec_count), .error(error));

  // Small instance: 4-entry address space
  logic        s_start = 1'b0, s_done = 1'b0;
  logic [1:0]  s_mem_addr, s_vec_count;
  logic [17:0] s_mem_data = '0;
  logic [7:0]  s_xs, s_ys, s_xe, s_ye;
  logic        s_pos, s_draw, s_busy, s_frame_done, s_error;
  logic [17:0] s_rom [0:3];
  always @(posedge clk) s_mem_data <= s_rom[s_mem_addr];

  vector_sequencer #(.OUT_WIDTH(8), .ADDR_WIDTH(2), .TIMEOUT(16)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .x_start(s_xs), .y_start(s_ys), .x_end(s_xe), .y_end(s_ye), .pos(s_pos), .draw(s_draw),
    .draw_done(s_done), .busy(s_busy), .frame_done(s_frame_done),
    .vec_count(s_vec_count), .error(s_error));

  int total = 0, bad = 0;
  int fd_cnt = 0, pos_cnt = 0, s_pos_cnt = 0, s_done_cnt = 0;
  logic [32:0] sb [$];   // {is_draw, x_start, y_start, x_end, y_end}

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ent(input logic [1:0] c, input logic [7:0] x, input logic [7:0] y);
    return {c, x, y};
  endfunction

  function automatic logic [32:0] req(input logic d, input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] e);
    return {d, a, b, c, e};
  endfunction

  // Request monitor / scoreboard consumer
  initial forever begin
    @(negedge clk);
    if (pos || draw) begin
      chk("excl", {63'd0, pos & draw}, 64'd0);
      if (sb.size() == 0) chk("unexp_req", 64'd1, 64'd0);
      else chk("req", {31'd0, draw, xs, ys, xe, ye}, {31'd0, sb.pop_front()});
    end
    if (pos) pos_cnt++;
    if (frame_done) fd_cnt++;
    if (s_pos) s_pos_cnt++;
  end

  // Rasteriser model: completion 5 cycles after each request
  initial forever begin
    @(negedge clk);
    if (auto_en && (pos || draw)) begin
      repeat (5) @(negedge clk);
      resp_done = 1'b1;
      @(negedge clk);
      resp_done = 1'b0;
    end
  end

  // Small instance rasteriser model
  initial forever begin
    @(negedge clk);
    if (s_pos || s_draw) begin
      repeat (2) @(negedge clk);
      s_done = 1'b1;
      s_done_cnt++;
      @(negedge clk);
      s_done = 1'b0;
    end
  end

  task automatic clr_rom();
    for (int i = 0; i < 1024; i++) rom[i] = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Counts negedges from the one after the start edge until a request shows.
  task automatic wait_req(output int n);
    n = 1;
    while (!(pos || draw) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", {63'd0, pos | draw}, 64'd1);
  endtask

  task automatic wait_fd(input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("fd_timeout", {63'd0, frame_done}, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int n, lat, fd0;
    logic [9:0] a;
    logic [9:0] aq [$];

    clr_rom();
    for (int i = 0; i < 4; i++) s_rom[i] = ent(2'b01, 8'(i + 1), 8'(i + 2));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {mem_addr, xs, ys, xe, ye, pos, draw, busy, frame_done, vec_count, error},
        64'd0);
    rst = 1'b1;

    // MOVE(10,20), DRAW(50,20), END
    rom[0] = ent(2'b01, 8'd10, 8'd20);
    rom[1] = ent(2'b10, 8'd50, 8'd20);
    sb.push_back(req(1'b0, 8'd0, 8'd0, 8'd10, 8'd20));
    sb.push_back(req(1'b1, 8'd10, 8'd20, 8'd50, 8'd20));
    pulse_start();
    wait_req(n);
    chk("lat_first_req", 64'(n), 64'd3);
    wait_fd(200);
    chk("busy_after_fd", {63'd0, busy}, 64'd0);
    chk("vc_t1", {54'd0, vec_count}, 64'd2);
    chk("sb_empty_t1", 64'(sb.size()), 64'd0);
    chk("fd_cnt_t1", 64'(fd_cnt), 64'd1);

    // Reset, then NOP, NOP, DRAW(3,4), END
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    clr_rom();
    rom[0] = ent(2'b11, 8'd0, 8'd0);
    rom[1] = ent(2'b11, 8'd0, 8'd0);
    rom[2] = ent(2'b10, 8'd3, 8'd4);
    sb.push_back(req(1'b1, 8'd0, 8'd0, 8'd3, 8'd4));
    pos_cnt = 0;
    pulse_start();
    n = 1; lat = 0;
    while (!frame_done && n < 200) begin
      if (aq.size() == 0 || aq[$] != mem_addr) aq.push_back(mem_addr);
      if ((pos || draw) && lat == 0) lat = n;
      @(negedge clk);
      n++;
    end
    chk("fd_timeout_t2", {63'd0, frame_done}, 64'd1);
    chk("nop_lat", 64'(lat), 64'd7);
    chk("addr_seq_len", 64'(aq.size()), 64'd4);
    if (aq.size() == 4) chk("addr_seq", {24'd0, aq[0], aq[1], aq[2], aq[3]},
                            {24'd0, 10'd0, 10'd1, 10'd2, 10'd3});
    @(negedge clk);
    chk("no_pos_t2", 64'(pos_cnt), 64'd0);
    chk("sb_empty_t2", 64'(sb.size()), 64'd0);

    // start during WAIT_DONE, spurious draw_done during FETCH
    clr_rom();
    rom[0] = ent(2'b01, 8'd7, 8'd8);
    rom[1] = ent(2'b10, 8'd9, 8'd9);
    sb.push_back(req(1'b0, 8'd3, 8'd4, 8'd7, 8'd8));
    sb.push_back(req(1'b1, 8'd7, 8'd8, 8'd9, 8'd9));
    pulse_start();
    wait_req(n);
    @(negedge clk);
    a = mem_addr;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("no_restart_addr", {54'd0, mem_addr}, {54'd0, a});
    chk("busy_in_wait", {63'd0, busy}, 64'd1);
    n = 0;
    while (!draw_done && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", {63'd0, draw_done}, 64'd1);
    @(negedge clk) spur = 1'b1;
    chk("addr_fetch", {54'd0, mem_addr}, 64'd1);
    @(negedge clk) spur = 1'b0;
    chk("addr_after_spur", {54'd0, mem_addr}, 64'd1);
    wait_fd(200);
    chk("vc_t3", {54'd0, vec_count}, 64'd2);
    chk("sb_empty_t3", 64'(sb.size()), 64'd0);

    // Small instance: 4 MOVEs, no END; vec_count saturates at 2'b11
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    n = 0;
    while (!s_frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s_fd_timeout", {63'd0, s_frame_done}, 64'd1);
    chk("s_done_at_fd", 64'(s_done_cnt), 64'd4);
    chk("s_pos_cnt", 64'(s_pos_cnt), 64'd4);
    chk("s_addr_wrap", {62'd0, s_mem_addr}, 64'd0);
    chk("s_vc_sat", {62'd0, s_vec_count}, 64'd3);
    chk("s_busy", {63'd0, s_busy}, 64'd0);

    // Asynchronous reset while in WAIT_DONE, then replay
    clr_rom();
    rom[0] = ent(2'b01, 8'd1, 8'd1);
    auto_en = 1'b0;
    sb.push_back(req(1'b0, 8'd9, 8'd9, 8'd1, 8'd1));
    pulse_start();
    wait_req(n);
    @(negedge clk);
    chk("pre_rst_xe", {56'd0, xe}, 64'd1);
    #2 rst = 1'b0;
    #1 chk("rst_async", {mem_addr, xs, ys, xe, ye, pos, draw, busy, frame_done, vec_count, error},
           64'd0);
    @(negedge clk) rst = 1'b1;
    auto_en = 1'b1;
    sb.push_back(req(1'b0, 8'd0, 8'd0, 8'd1, 8'd1));
    pulse_start();
    wait_req(n);
    chk("replay_addr", {54'd0, mem_addr}, 64'd0);
    wait_fd(200);
    chk("vc_t6", {54'd0, vec_count}, 64'd1);
    chk("sb_empty_t6", 64'(sb.size()), 64'd0);

`ifdef VECSEQ_WATCHDOG_EN
    // Watchdog: DRAW with draw_done withheld
    clr_rom();
    rom[0] = ent(2'b10, 8'd5, 8'd5);
    auto_en = 1'b0;
    sb.push_back(req(1'b1, 8'd1, 8'd1, 8'd5, 8'd5));
    fd0 = fd_cnt;
    pulse_start();
    wait_req(n);
    repeat (15) @(negedge clk);
    chk("wd_early", {63'd0, error}, 64'd0);
    @(negedge clk);
    chk("wd_error", {63'd0, error}, 64'd1);
    chk("wd_idle", {63'd0, busy}, 64'd0);
    chk("wd_addr", {54'd0, mem_addr}, 64'd0);
    @(negedge clk);
    chk("wd_no_fd", 64'(fd_cnt), 64'(fd0));
    auto_en = 1'b1;
    sb.push_back(req(1'b1, 8'd1, 8'd1, 8'd5, 8'd5));
    pulse_start();
    chk("wd_err_clr", {63'd0, error}, 64'd0);
    wait_fd(200);
    chk("sb_empty_wd", 64'(sb.size()), 64'd0);
`else
    fd0 = fd_cnt;
    chk("no_wd_error", {63'd0, error}, 64'd0);
    chk("fd_stable", 64'(fd_cnt), 64'(fd0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
